// File: rtl/sap_control_sequencer.sv
// Microcode step sequencer and control-word decoder for the SAP bus CPU.
// Emits one combinational control word per clock step from step/opcode/flags.
module sap_control_sequencer #(
  parameter bit EARLY_END = 1'b1,
  parameter int NUM_STEPS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_inc,
  output logic       pc_oe,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halt,
  output logic [2:0] step,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5
  } step_t;

  localparam step_t LAST_T = step_t'(3'(NUM_STEPS - 1));

  step_t step_q, step_d;
  logic  halted_q, halted_d;
  step_t last;
  logic  is_hlt;

  assign step = step_q;

  // Step counter and halted bit; reset aborts any instruction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Decode control word, last active step and next step.
  always_comb begin
    pc_inc     = 1'b0;
    pc_oe      = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_oe     = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_oe      = 1'b0;
    a_load     = 1'b0;
    a_oe       = 1'b0;
    b_load     = 1'b0;
    alu_oe     = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    step_d     = step_q;
    halted_d   = halted_q;
    last       = T2;
    is_hlt     = 1'b0;

    case (opcode)
      4'h1:    last = T3;
      4'h2:    last = T4;
      4'h3:    last = T4;
      4'h4:    last = T3;
      4'hF:    is_hlt = 1'b1;
      default: last = T2;
    endcase
    // Without early end every instruction idles out to the final step.
    if (!EARLY_END && !is_hlt) last = LAST_T;

    if (reset) begin
      halt = 1'b0;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          pc_oe    = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_oe  = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        default: begin
          case (opcode)
            4'h1: begin
              if (step_q == T2) begin
                ir_oe    = 1'b1;
                mar_load = 1'b1;
              end else if (step_q == T3) begin
                ram_oe = 1'b1;
                a_load = 1'b1;
              end
            end
            4'h2, 4'h3: begin
              if (step_q == T2) begin
                ir_oe    = 1'b1;
                mar_load = 1'b1;
              end else if (step_q == T3) begin
                ram_oe = 1'b1;
                b_load = 1'b1;
              end else if (step_q == T4) begin
                alu_oe     = 1'b1;
                a_load     = 1'b1;
                flags_load = 1'b1;
                alu_sub    = opcode[0];
              end
            end
            4'h4: begin
              if (step_q == T2) begin
                ir_oe    = 1'b1;
                mar_load = 1'b1;
              end else if (step_q == T3) begin
                a_oe     = 1'b1;
                ram_load = 1'b1;
              end
            end
            4'h5: begin
              ir_oe  = (step_q == T2);
              a_load = (step_q == T2);
            end
            4'h6: begin
              ir_oe   = (step_q == T2);
              pc_load = (step_q == T2);
            end
            4'h7: begin
              ir_oe   = (step_q == T2) && carry_flag;
              pc_load = (step_q == T2) && carry_flag;
            end
            4'h8: begin
              ir_oe   = (step_q == T2) && zero_flag;
              pc_load = (step_q == T2) && zero_flag;
            end
            4'hE: begin
              a_oe     = (step_q == T2);
              out_load = (step_q == T2);
            end
            default: begin
              ir_oe = 1'b0;
            end
          endcase
        end
      endcase

      if (is_hlt && step_q == T2) begin
        halt     = 1'b1;
        halted_d = 1'b1;
      end else if (step_q == last) begin
        instr_done = 1'b1;
        step_d     = T0;
      end else begin
        step_d = step_t'(step_q + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: early-end and full-cycle
// instances, fetch/execute words, flags, halt and asynchronous reset.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic       carry;
  logic       zero;

  logic       pc_inc0, pc_oe0, pc_load0, mar_load0, ram_oe0, ram_load0;
  logic       ir_load0, ir_oe0, a_load0, a_oe0, b_load0, alu_oe0;
  logic       alu_sub0, flags_load0, out_load0, halt0, done0;
  logic [2:0] step0;
  logic       pc_inc1, pc_oe1, pc_load1, mar_load1, ram_oe1, ram_load1;
  logic       ir_load1, ir_oe1, a_load1, a_oe1, b_load1, alu_oe1;
  logic       alu_sub1, flags_load1, out_load1, halt1, done1;
  logic [2:0] step1;

  localparam logic [15:0] PC_INC = 16'h8000;
  localparam logic [15:0] PC_OE  = 16'h4000;
  localparam logic [15:0] PC_LD  = 16'h2000;
  localparam logic [15:0] MAR_LD = 16'h1000;
  localparam logic [15:0] RAM_OE = 16'h0800;
  localparam logic [15:0] RAM_LD = 16'h0400;
  localparam logic [15:0] IR_LD  = 16'h0200;
  localparam logic [15:0] IR_OE  = 16'h0100;
  localparam logic [15:0] A_LD   = 16'h0080;
  localparam logic [15:0] A_OE   = 16'h0040;
  localparam logic [15:0] B_LD   = 16'h0020;
  localparam logic [15:0] ALU_OE = 16'h0010;
  localparam logic [15:0] SUB    = 16'h0008;
  localparam logic [15:0] FL_LD  = 16'h0004;
  localparam logic [15:0] OUT_LD = 16'h0002;
  localparam logic [15:0] HALT   = 16'h0001;
  localparam logic [15:0] F0     = PC_OE | MAR_LD;
  localparam logic [15:0] F1     = RAM_OE | IR_LD | PC_INC;

  logic [15:0] cw0, cw1;
  assign cw0 = {pc_inc0, pc_oe0, pc_load0, mar_load0, ram_oe0, ram_load0,
                ir_load0, ir_oe0, a_load0, a_oe0, b_load0, alu_oe0,
                alu_sub0, flags_load0, out_load0, halt0};
  assign cw1 = {pc_inc1, pc_oe1, pc_load1, mar_load1, ram_oe1, ram_load1,
                ir_load1, ir_oe1, a_load1, a_oe1, b_load1, alu_oe1,
                alu_sub1, flags_load1, out_load1, halt1};

  int checks = 0;
  int failures = 0;
  int aload_seen = 0;
  bit watch = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (watch && a_load0) aload_seen <= aload_seen + 1;

  sap_control_sequencer #(.EARLY_END(1'b1), .NUM_STEPS(6)) dut0 (
    .clk(clk), .reset(rst), .opcode(op),
    .carry_flag(carry), .zero_flag(zero),
    .pc_inc(pc_inc0), .pc_oe(pc_oe0), .pc_load(pc_load0),
    .mar_load(mar_load0), .ram_oe(ram_oe0), .ram_load(ram_load0),
    .ir_load(ir_load0), .ir_oe(ir_oe0), .a_load(a_load0),
    .a_oe(a_oe0), .b_load(b_load0), .alu_oe(alu_oe0),
    .alu_sub(alu_sub0), .flags_load(flags_load0),
    .out_load(out_load0), .halt(halt0), .step(step0),
    .instr_done(done0)
  );

  sap_control_sequencer #(.EARLY_END(1'b0), .NUM_STEPS(6)) dut1 (
    .clk(clk), .reset(rst), .opcode(op),
    .carry_flag(carry), .zero_flag(zero),
    .pc_inc(pc_inc1), .pc_oe(pc_oe1), .pc_load(pc_load1),
    .mar_load(mar_load1), .ram_oe(ram_oe1), .ram_load(ram_load1),
    .ir_load(ir_load1), .ir_oe(ir_oe1), .a_load(a_load1),
    .a_oe(a_oe1), .b_load(b_load1), .alu_oe(alu_oe1),
    .alu_sub(alu_sub1), .flags_load(flags_load1),
    .out_load(out_load1), .halt(halt1), .step(step1),
    .instr_done(done1)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input bit inst,
                     input logic [15:0] ecw, input logic [2:0] est,
                     input logic edone);
    logic [15:0] c;
    logic [2:0]  s;
    logic        d;
    c = inst ? cw1 : cw0;
    s = inst ? step1 : step0;
    d = inst ? done1 : done0;
    checks++;
    assert ({c, s, d} === {ecw, est, edone}) else begin
      failures++;
      $error("FAIL %s: got cw=%h step=%0d done=%b, expected cw=%h step=%0d done=%b",
             tag, c, s, d, ecw, est, edone);
    end
  endtask

  task automatic fetch(input string tag);
    tick;
    chk({tag, "_t1"}, 1'b0, F1, 3'd1, 1'b0);
    tick;
  endtask

  initial begin
    rst = 1'b1;
    op = 4'h0;
    carry = 1'b0;
    zero = 1'b0;
    tick;
    tick;
    chk("reset0", 1'b0, 16'h0, 3'd0, 1'b0);
    chk("reset1", 1'b1, 16'h0, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("nop_t0", 1'b0, F0, 3'd0, 1'b0);
    fetch("nop");
    chk("nop_t2", 1'b0, 16'h0, 3'd2, 1'b1);
    tick;
    chk("nop_wrap", 1'b0, F0, 3'd0, 1'b0);

    op = 4'h2;
    fetch("add");
    chk("add_t2", 1'b0, IR_OE | MAR_LD, 3'd2, 1'b0);
    tick;
    chk("add_t3", 1'b0, RAM_OE | B_LD, 3'd3, 1'b0);
    tick;
    chk("add_t4", 1'b0, ALU_OE | A_LD | FL_LD, 3'd4, 1'b1);
    tick;
    chk("add_wrap", 1'b0, F0, 3'd0, 1'b0);

    op = 4'h3;
    fetch("sub");
    chk("sub_t2", 1'b0, IR_OE | MAR_LD, 3'd2, 1'b0);
    tick;
    chk("sub_t3", 1'b0, RAM_OE | B_LD, 3'd3, 1'b0);
    tick;
    chk("sub_t4", 1'b0, ALU_OE | A_LD | FL_LD | SUB, 3'd4, 1'b1);
    tick;

    op = 4'h7;
    carry = 1'b0;
    fetch("jc0");
    chk("jc_nc_t2", 1'b0, 16'h0, 3'd2, 1'b1);
    tick;
    fetch("jc1");
    chk("jc_late0", 1'b0, 16'h0, 3'd2, 1'b1);
    carry = 1'b1;
    #1;
    chk("jc_c_t2", 1'b0, IR_OE | PC_LD, 3'd2, 1'b1);
    tick;
    carry = 1'b0;
    chk("jc_wrap", 1'b0, F0, 3'd0, 1'b0);

    op = 4'h8;
    zero = 1'b0;
    fetch("jz0");
    chk("jz_nz_t2", 1'b0, 16'h0, 3'd2, 1'b1);
    tick;
    zero = 1'b1;
    fetch("jz1");
    chk("jz_z_t2", 1'b0, IR_OE | PC_LD, 3'd2, 1'b1);
    tick;
    zero = 1'b0;

    op = 4'hA;
    fetch("undef");
    chk("undef_t2", 1'b0, 16'h0, 3'd2, 1'b1);
    tick;

    op = 4'h4;
    fetch("sta");
    chk("sta_t2", 1'b0, IR_OE | MAR_LD, 3'd2, 1'b0);
    tick;
    chk("sta_t3", 1'b0, A_OE | RAM_LD, 3'd3, 1'b1);
    tick;

    op = 4'hE;
    fetch("out");
    chk("out_t2", 1'b0, A_OE | OUT_LD, 3'd2, 1'b1);
    tick;

    op = 4'h6;
    fetch("jmp");
    chk("jmp_t2", 1'b0, IR_OE | PC_LD, 3'd2, 1'b1);
    tick;

    op = 4'h1;
    fetch("lda");
    chk("lda_t2", 1'b0, IR_OE | MAR_LD, 3'd2, 1'b0);
    tick;
    chk("lda_t3", 1'b0, RAM_OE | A_LD, 3'd3, 1'b1);
    watch = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("lda_abort", 1'b0, 16'h0, 3'd0, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("lda_rel_t0", 1'b0, F0, 3'd0, 1'b0);
    watch = 1'b0;
    checks++;
    assert (aload_seen === 0) else begin
      failures++;
      $error("FAIL lda_no_aload: got %0d a_load edges, expected 0", aload_seen);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;

    op = 4'hF;
    fetch("hlt");
    chk("hlt_t2", 1'b0, HALT, 3'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) op = 4'h0;
      tick;
      chk("halted", 1'b0, HALT, 3'd2, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("hlt_rst0", 1'b0, 16'h0, 3'd0, 1'b0);
    chk("hlt_rst1", 1'b1, 16'h0, 3'd0, 1'b0);
    tick;
    rst = 1'b0;
    #1;
    chk("post_hlt_t0", 1'b0, F0, 3'd0, 1'b0);

    op = 4'h5;
    chk("ldi_full_t0", 1'b1, F0, 3'd0, 1'b0);
    tick;
    chk("ldi_full_t1", 1'b1, F1, 3'd1, 1'b0);
    tick;
    chk("ldi_full_t2", 1'b1, IR_OE | A_LD, 3'd2, 1'b0);
    chk("ldi_early_t2", 1'b0, IR_OE | A_LD, 3'd2, 1'b1);
    tick;
    chk("ldi_full_t3", 1'b1, 16'h0, 3'd3, 1'b0);
    chk("ldi_early_wrap", 1'b0, F0, 3'd0, 1'b0);
    tick;
    chk("ldi_full_t4", 1'b1, 16'h0, 3'd4, 1'b0);
    tick;
    chk("ldi_full_t5", 1'b1, 16'h0, 3'd5, 1'b1);
    tick;
    chk("ldi_full_wrap", 1'b1, F0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Microcode step sequencer and decoder for the 8-bit bus CPU.
- Consumes the opcode nibble from the instruction register and the ALU flag register.
- Drives the `load` / `output_enable` (oe) strobes of every bus register: PC, MAR, RAM, IR, A, B, ALU, OUT.
- Sits directly upstream of the register file; one control word per clock step.

Parameters:
- EARLY_END, 1, 1 = step counter returns to T0 after an instruction's last active step; 0 = every instruction runs the full T0..T5.
- NUM_STEPS, 6, number of steps in a full cycle (T0..T5); step counter is 3 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears step counter and halt state
- opcode  input  4  IR upper nibble (IR.Q[7:4])
- carry_flag  input  1  registered ALU carry
- zero_flag  input  1  registered ALU zero
- pc_inc  output  1  program counter increment
- pc_oe  output  1  PC drives bus
- pc_load  output  1  PC loads from bus
- mar_load  output  1  MAR loads from bus
- ram_oe  output  1  RAM drives bus
- ram_load  output  1  RAM writes from bus
- ir_load  output  1  IR loads from bus
- ir_oe  output  1  IR low nibble drives bus
- a_load  output  1  A register load
- a_oe  output  1  A drives bus
- b_load  output  1  B register load
- alu_oe  output  1  ALU result drives bus
- alu_sub  output  1  ALU subtract select
- flags_load  output  1  flag register captures carry/zero
- out_load  output  1  output register load
- halt  output  1  CPU halted; clock gating handled externally
- step  output  3  current step T0..T5 (debug)
- instr_done  output  1  high during the final step of the current instruction

Behaviour:
- State:
  - 3-bit step counter, reset to 0.
  - Halted bit, reset to 0.
- Output timing:
  - Control outputs are combinational decode of (step, opcode, flags, halted).
  - Strobes asserted in step Tn take effect at the posedge ending Tn.
  - The step counter advances on that same edge.
- Reset:
  - While reset = 1, all control outputs and instr_done are 0, and step = 0.
  - Reset asserted mid-instruction aborts it immediately; there is no partial completion.
  - After reset deasserts, T0 decode is visible in the same cycle.
- Fetch (all opcodes):
  - T0: pc_oe, mar_load.
  - T1: ram_oe, ir_load, pc_inc.
- Execute (T2 onward):
  - NOP 0000, and every undefined opcode (1001..1101): no strobes; last step T2.
  - LDA 0001:
    - T2: ir_oe, mar_load.
    - T3: ram_oe, a_load. Last step T3.
  - ADD 0010:
    - T2: ir_oe, mar_load.
    - T3: ram_oe, b_load.
    - T4: alu_oe, a_load, flags_load. Last step T4.
  - SUB 0011: same as ADD, with alu_sub = 1 in T4 only.
  - STA 0100:
    - T2: ir_oe, mar_load.
    - T3: a_oe, ram_load. Last step T3.
  - LDI 0101: T2: ir_oe, a_load. Last step T2.
  - JMP 0110: T2: ir_oe, pc_load. Last step T2.
  - JC 0111: T2: ir_oe and pc_load only if carry_flag = 1, otherwise nothing. Last step T2.
  - JZ 1000: same as JC, using zero_flag.
  - OUT 1110: T2: a_oe, out_load. Last step T2.
  - HLT 1111: T2: halt = 1; halted bit sets on the posedge ending T2.
- Step advance:
  - EARLY_END = 1: after the last step, step returns to 0.
  - EARLY_END = 0: idle steps up to T5 produce no strobes, then step returns to 0.
  - instr_done = 1 in the step that precedes the return to 0, including idle T5 when EARLY_END = 0.
- Halted state:
  - step frozen at its value.
  - halt = 1; all other strobes 0; instr_done = 0.
  - Only reset exits the halted state.
- Flags are sampled combinationally during T2. A flag change in T2 before the edge is honoured; changes after that edge are ignored.
- Invariants:
  - At most one oe output is high in any step.
  - ir_load is never high outside T1.
- Opcode is assumed stable from the T1 edge onward. The decoder uses the live opcode value at T2..T5.

Test Plan:
- Reset, then 2 clocks with opcode = 0000 → T0: pc_oe = mar_load = 1; T1: ram_oe = ir_load = pc_inc = 1; T2: no strobes, instr_done = 1; next step = 0.
- Opcode = 0010 (ADD), EARLY_END = 1 → T3: ram_oe = b_load = 1; T4: alu_oe = a_load = flags_load = 1, alu_sub = 0, instr_done = 1; 5-cycle instruction. Repeat with 0011 → alu_sub = 1 only in T4.
- Opcode = 0111 with carry_flag = 0 → no pc_load in T2. Repeat with carry_flag = 1 → ir_oe = pc_load = 1 in T2. Same pair for JZ with zero_flag.
- Opcode = 1111 → halt = 1 from T2 onward, step stays 2 for 10+ clocks, all strobes 0. Assert reset → halt = 0, step = 0.
- Assert reset asynchronously mid-T3 of LDA (between edges) → strobes drop to 0 immediately without a clock edge. After release, T0 decode appears and no a_load ever occurred.
- EARLY_END = 0, opcode = 0101 (LDI) → T2: ir_oe = a_load = 1; T3..T5 all strobes 0; instr_done only in T5; 6 cycles per instruction.
